// File: rtl/rv_iopmp_entry_encoder_if.sv
// Entry mode / response code package and the request, entry-write and
// response channel bundle shared by the IOPMP entry encoder and its users.
package rv_iopmp_pkg;
    typedef enum logic [1:0] {OFF = 2'd0, TOR = 2'd1, NA4 = 2'd2, NAPOT = 2'd3} mode_t;
    typedef enum logic [1:0] {ERR_OK, ERR_ALIGN, ERR_NO_ENTRIES, ERR_RANGE} err_t;
endpackage

interface rv_iopmp_entry_encoder_if #(
    parameter int unsigned LEN         = 32,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned NUM_ENTRIES = 16
);
    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);

    logic                    req_valid_i;
    logic                    req_ready_o;
    logic [ADDR_WIDTH-1:0]   req_base_i;
    logic [ADDR_WIDTH-1:0]   req_len_i;
    logic [2:0]              req_perm_i;
    logic [IDX_W-1:0]        req_idx_i;
    logic [IDX_W-1:0]        req_last_i;

    logic                    wr_valid_o;
    logic                    wr_ready_i;
    logic [IDX_W-1:0]        wr_idx_o;
    logic [LEN-1:0]          wr_addr_o;
    logic [LEN-1:0]          wr_addrh_o;
    rv_iopmp_pkg::mode_t     wr_mode_o;
    logic [2:0]              wr_perm_o;

    logic                    rsp_valid_o;
    logic                    rsp_ready_i;
    logic [1:0]              rsp_err_o;
    logic [IDX_W:0]          rsp_count_o;

    modport slave (
        input  req_valid_i, req_base_i, req_len_i, req_perm_i, req_idx_i, req_last_i,
        input  wr_ready_i, rsp_ready_i,
        output req_ready_o, wr_valid_o, wr_idx_o, wr_addr_o, wr_addrh_o, wr_mode_o, wr_perm_o,
        output rsp_valid_o, rsp_err_o, rsp_count_o
    );

    modport master (
        output req_valid_i, req_base_i, req_len_i, req_perm_i, req_idx_i, req_last_i,
        output wr_ready_i, rsp_ready_i,
        input  req_ready_o, wr_valid_o, wr_idx_o, wr_addr_o, wr_addrh_o, wr_mode_o, wr_perm_o,
        input  rsp_valid_o, rsp_err_o, rsp_count_o
    );
endinterface

// File: rtl/rv_iopmp_entry_encoder.sv
// Splits an address region into IOPMP NA4/NAPOT entry writes, one per handshake.
// Optional RV_IOPMP_ENCODER_TOR_EN: non-block regions become an OFF+TOR entry pair.
module rv_iopmp_entry_encoder #(
    parameter int unsigned LEN         = 32,
    parameter int unsigned ADDR_WIDTH  = 64,
    parameter int unsigned NUM_ENTRIES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    rv_iopmp_entry_encoder_if.slave bus
);
    import rv_iopmp_pkg::*;

    localparam int unsigned IDX_W = $clog2(NUM_ENTRIES);
    localparam int unsigned KW    = $clog2(ADDR_WIDTH + 1);
    localparam int unsigned EW    = (2 * LEN > ADDR_WIDTH) ? 2 * LEN : ADDR_WIDTH;

    typedef enum logic [1:0] {S_IDLE, S_EMIT, S_RESP} state_t;

    state_t                r_state, w_next;
    logic [ADDR_WIDTH-1:0] r_base, r_rem;
    logic [2:0]            r_perm;
    logic [IDX_W-1:0]      r_idx, r_last;
    logic [IDX_W:0]        r_count;
    err_t                  r_err;

    logic [ADDR_WIDTH:0]   w_sum;
    err_t                  w_chk_err;
    logic [KW-1:0]         w_tz, w_lg, w_k;
    logic [ADDR_WIDTH-1:0] w_blk, w_entry;
    logic [EW-1:0]         w_entry_ext;
    mode_t                 w_mode;
    logic                  w_done_ok, w_done_full;
`ifdef RV_IOPMP_ENCODER_TOR_EN
    logic [ADDR_WIDTH:0]   r_end;
    logic                  r_tor, r_phase;
    logic                  w_single;
    logic [ADDR_WIDTH-1:0] w_len_m1;
`endif

    // Request checks: ALIGN beats RANGE; the sum is one bit wider so 2^ADDR_WIDTH is legal.
    always_comb begin
        w_sum     = {1'b0, bus.req_base_i} + {1'b0, bus.req_len_i};
        w_chk_err = ERR_OK;
`ifdef RV_IOPMP_ENCODER_TOR_EN
        w_len_m1  = bus.req_len_i - ADDR_WIDTH'(1);
        w_single  = ((bus.req_len_i & w_len_m1) == '0) && ((bus.req_base_i & w_len_m1) == '0);
`endif
        if (bus.req_base_i[1:0] != 2'b00 || bus.req_len_i[1:0] != 2'b00 || bus.req_len_i == '0)
            w_chk_err = ERR_ALIGN;
        else if ((w_sum[ADDR_WIDTH] && w_sum[ADDR_WIDTH-1:0] != '0) ||
                 bus.req_idx_i > bus.req_last_i)
            w_chk_err = ERR_RANGE;
`ifdef RV_IOPMP_ENCODER_TOR_EN
        else if (!w_single && !(bus.req_idx_i < bus.req_last_i))
            w_chk_err = ERR_NO_ENTRIES;
`endif
    end

    // Block exponent: min(trailing zeros of base, floor(log2(remaining))).
    always_comb begin
        w_tz = KW'(ADDR_WIDTH);
        w_lg = '0;
        for (int unsigned i = 0; i < ADDR_WIDTH; i++) begin
            if (r_base[i] && w_tz == KW'(ADDR_WIDTH)) w_tz = KW'(i);
            if (r_rem[i]) w_lg = KW'(i);
        end
        w_k   = (w_tz < w_lg) ? w_tz : w_lg;
        w_blk = ADDR_WIDTH'(1) << w_k;

        if (w_k == KW'(2)) begin
            w_mode  = NA4;
            w_entry = r_base >> 2;
        end else begin
            w_mode  = NAPOT;
            w_entry = (r_base >> 2) | ((w_blk >> 3) - ADDR_WIDTH'(1));
        end
        w_done_ok   = (r_rem == w_blk);
        w_done_full = !w_done_ok && (r_idx == r_last);
`ifdef RV_IOPMP_ENCODER_TOR_EN
        if (r_tor) begin
            w_mode      = r_phase ? TOR : OFF;
            w_entry     = r_phase ? ADDR_WIDTH'(r_end >> 2) : (r_base >> 2);
            w_done_ok   = r_phase;
            w_done_full = 1'b0;
        end
`endif
        w_entry_ext = EW'(w_entry);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    always_comb begin
        w_next          = r_state;
        bus.req_ready_o = 1'b0;
        bus.wr_valid_o  = 1'b0;
        bus.rsp_valid_o = 1'b0;
        bus.wr_idx_o    = '0;
        bus.wr_addr_o   = '0;
        bus.wr_addrh_o  = '0;
        bus.wr_mode_o   = OFF;
        bus.wr_perm_o   = '0;
        bus.rsp_err_o   = r_err;
        bus.rsp_count_o = r_count;
        case (r_state)
            S_IDLE: begin
                bus.req_ready_o = 1'b1;
                if (bus.req_valid_i) w_next = (w_chk_err == ERR_OK) ? S_EMIT : S_RESP;
            end
            S_EMIT: begin
                bus.wr_valid_o = 1'b1;
                bus.wr_idx_o   = r_idx;
                bus.wr_mode_o  = w_mode;
                bus.wr_perm_o  = r_perm;
                {bus.wr_addrh_o, bus.wr_addr_o} = w_entry_ext[2*LEN-1:0];
                if (bus.wr_ready_i && (w_done_ok || w_done_full)) w_next = S_RESP;
            end
            S_RESP: begin
                bus.rsp_valid_o = 1'b1;
                if (bus.rsp_ready_i) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_base  <= '0;
            r_rem   <= '0;
            r_perm  <= '0;
            r_idx   <= '0;
            r_last  <= '0;
            r_count <= '0;
            r_err   <= ERR_OK;
`ifdef RV_IOPMP_ENCODER_TOR_EN
            r_end   <= '0;
            r_tor   <= 1'b0;
            r_phase <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.req_valid_i) begin
                    r_base  <= bus.req_base_i;
                    r_rem   <= bus.req_len_i;
                    r_perm  <= bus.req_perm_i;
                    r_idx   <= bus.req_idx_i;
                    r_last  <= bus.req_last_i;
                    r_count <= '0;
                    r_err   <= w_chk_err;
`ifdef RV_IOPMP_ENCODER_TOR_EN
                    r_end   <= w_sum;
                    r_tor   <= !w_single;
                    r_phase <= 1'b0;
`endif
                end
                S_EMIT: if (bus.wr_ready_i) begin
                    r_base  <= r_base + w_blk;
                    r_rem   <= r_rem - w_blk;
                    r_idx   <= r_idx + IDX_W'(1);
                    r_count <= r_count + (IDX_W + 1)'(1);
                    if (w_done_full) r_err <= ERR_NO_ENTRIES;
`ifdef RV_IOPMP_ENCODER_TOR_EN
                    r_phase <= 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_rv_iopmp_entry_encoder.sv
// Scoreboard bench for rv_iopmp_entry_encoder: directed regions with hand-computed entries.
module tb_rv_iopmp_entry_encoder;
    import rv_iopmp_pkg::*;

    localparam int unsigned LEN = 32;
    localparam int unsigned AW  = 64;
    localparam int unsigned NE  = 16;
    localparam int unsigned IW  = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    rv_iopmp_entry_encoder_if #(.LEN(LEN), .ADDR_WIDTH(AW), .NUM_ENTRIES(NE)) bus ();

    rv_iopmp_entry_encoder #(.LEN(LEN), .ADDR_WIDTH(AW), .NUM_ENTRIES(NE)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .bus    (bus)
    );

    typedef struct {
        bit              is_rsp;
        logic [IW-1:0]   idx;
        logic [1:0]      mode;
        logic [63:0]     val;
        logic [2:0]      perm;
        logic [1:0]      err;
        logic [IW:0]     cnt;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    task automatic exp_wr(input logic [IW-1:0] idx, input logic [1:0] mode,
                          input logic [63:0] val, input logic [2:0] perm);
        exp_t e;
        e = '{is_rsp: 1'b0, idx: idx, mode: mode, val: val, perm: perm, err: 2'd0, cnt: '0};
        sb.push_back(e);
    endtask

    task automatic exp_rsp(input logic [1:0] err, input logic [IW:0] cnt);
        exp_t e;
        e = '{is_rsp: 1'b1, idx: '0, mode: 2'd0, val: '0, perm: '0, err: err, cnt: cnt};
        sb.push_back(e);
    endtask

    // Monitor: every handshake that the next rising edge will complete is checked here.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bus.wr_valid_o && bus.wr_ready_i) begin
                if (sb.size() == 0 || sb[0].is_rsp) begin
                    n_checks++; n_errors++;
                    $display("FAIL wr_unexpected: got idx %0d val %0h, no write expected",
                             bus.wr_idx_o, {bus.wr_addrh_o, bus.wr_addr_o});
                end else begin
                    e = sb.pop_front();
                    check("wr", {bus.wr_idx_o, 2'(bus.wr_mode_o), bus.wr_addrh_o, bus.wr_addr_o, bus.wr_perm_o},
                          {e.idx, e.mode, e.val, e.perm});
                end
            end
            if (rst_n && bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (sb.size() == 0 || !sb[0].is_rsp) begin
                    n_checks++; n_errors++;
                    $display("FAIL rsp_unexpected: got err %0d count %0d, no response expected",
                             bus.rsp_err_o, bus.rsp_count_o);
                end else begin
                    e = sb.pop_front();
                    check("rsp", {bus.rsp_err_o, bus.rsp_count_o}, {e.err, e.cnt});
                end
            end
        end
    end

    task automatic send_req(input logic [63:0] base, input logic [63:0] len, input logic [2:0] perm,
                            input logic [IW-1:0] idx, input logic [IW-1:0] last);
        bit ok = 1'b0;
        bus.req_base_i  = base;
        bus.req_len_i   = len;
        bus.req_perm_i  = perm;
        bus.req_idx_i   = idx;
        bus.req_last_i  = last;
        bus.req_valid_i = 1'b1;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (bus.req_ready_o) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL req_timeout: got req_ready_o 0, expected 1 within 100 cycles");
        end
        @(posedge clk); #1;
        bus.req_valid_i = 1'b0;
    endtask

    task automatic drain();
        bit ok = 1'b0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (sb.size() == 0) begin ok = 1'b1; break; end
        end
        if (!ok) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: got %0d pending, expected 0", sb.size());
            sb.delete();
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", bus.req_ready_o, 1);
        check("rst_wr_valid",  bus.wr_valid_o, 0);
        check("rst_rsp_valid", bus.rsp_valid_o, 0);
        check("rst_rsp",       {bus.rsp_err_o, bus.rsp_count_o}, 0);
        check("rst_wr_fields", {bus.wr_idx_o, 2'(bus.wr_mode_o), bus.wr_addrh_o, bus.wr_addr_o, bus.wr_perm_o}, 0);
    endtask

    initial begin
        #2_000_000;
        n_errors++;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_base_i  = '0;
        bus.req_len_i   = '0;
        bus.req_perm_i  = '0;
        bus.req_idx_i   = '0;
        bus.req_last_i  = '0;
        bus.wr_ready_i  = 1'b1;
        bus.rsp_ready_i = 1'b1;
        #1 rst_n = 1'b0;
        #12 check_reset_outputs();
        @(posedge clk); #1 rst_n = 1'b1;

        // Single aligned 4 KiB block
        exp_wr(0, NAPOT, 64'h2000_01FF, 3'b011); exp_rsp(2'd0, 1);
        send_req(64'h8000_0000, 64'h1000, 3'b011, 0, 15); drain();

        exp_wr(0, NA4, 64'h400, 3'b001); exp_rsp(2'd0, 1);
        send_req(64'h1000, 64'h4, 3'b001, 0, 15); drain();

`ifdef RV_IOPMP_ENCODER_TOR_EN
        exp_wr(0, OFF, 64'h401, 3'b101); exp_wr(1, TOR, 64'h404, 3'b101);
`else
        exp_wr(0, NA4, 64'h401, 3'b101); exp_wr(1, NAPOT, 64'h402, 3'b101);
`endif
        exp_rsp(2'd0, 2);
        send_req(64'h1004, 64'hC, 3'b101, 0, 15); drain();

        // Alignment and range errors, ALIGN taking priority
        exp_rsp(2'd1, 0); send_req(64'h1002, 64'h10, 3'b111, 0, 15); drain();
        exp_rsp(2'd1, 0); send_req(64'h1000, 64'h0, 3'b111, 0, 15); drain();
        exp_rsp(2'd1, 0); send_req(64'h1000, 64'h6, 3'b111, 0, 15); drain();
        exp_rsp(2'd3, 0); send_req(64'hFFFF_FFFF_FFFF_F000, 64'h2000, 3'b001, 0, 15); drain();
        exp_rsp(2'd1, 0); send_req(64'hFFFF_FFFF_FFFF_F002, 64'h2000, 3'b001, 0, 15); drain();
        exp_rsp(2'd3, 0); send_req(64'h1000, 64'h4, 3'b001, 5, 4); drain();

        // Last block ends exactly at 2^64
        exp_wr(7, NAPOT, 64'h3FFF_FFFF_FFFF_FDFF, 3'b100); exp_rsp(2'd0, 1);
        send_req(64'hFFFF_FFFF_FFFF_F000, 64'h1000, 3'b100, 7, 15); drain();

        // Running out of entries
`ifdef RV_IOPMP_ENCODER_TOR_EN
        exp_wr(14, OFF, 64'h401, 3'b011); exp_wr(15, TOR, 64'hC00, 3'b011); exp_rsp(2'd0, 2);
`else
        exp_wr(14, NA4, 64'h401, 3'b011); exp_wr(15, NAPOT, 64'h402, 3'b011); exp_rsp(2'd2, 2);
`endif
        send_req(64'h1004, 64'h1FFC, 3'b011, 14, 15); drain();

`ifdef RV_IOPMP_ENCODER_TOR_EN
        exp_rsp(2'd2, 0);
`else
        exp_wr(15, NA4, 64'h401, 3'b010); exp_rsp(2'd2, 1);
`endif
        send_req(64'h1004, 64'hC, 3'b010, 15, 15); drain();

        // Response held under backpressure
        bus.rsp_ready_i = 1'b0;
        exp_wr(3, NA4, 64'h400, 3'b111); exp_rsp(2'd0, 1);
        send_req(64'h1000, 64'h4, 3'b111, 3, 15);
        repeat (2) @(negedge clk);
        for (int c = 0; c < 3; c++) begin
            check("rsp_hold", {bus.rsp_valid_o, bus.rsp_err_o, bus.rsp_count_o}, {1'b1, 2'd0, 5'd1});
            @(negedge clk);
        end
        @(posedge clk); #1 bus.rsp_ready_i = 1'b1;
        drain();

        // Write backpressure: outputs must hold the first entry for 5 cycles
        bus.wr_ready_i = 1'b0;
`ifdef RV_IOPMP_ENCODER_TOR_EN
        exp_wr(2, OFF, 64'h401, 3'b110); exp_wr(3, TOR, 64'h404, 3'b110);
`else
        exp_wr(2, NA4, 64'h401, 3'b110); exp_wr(3, NAPOT, 64'h402, 3'b110);
`endif
        exp_rsp(2'd0, 2);
        send_req(64'h1004, 64'hC, 3'b110, 2, 15);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("wr_stall", {bus.wr_valid_o, bus.wr_idx_o, 2'(bus.wr_mode_o), bus.wr_addrh_o, bus.wr_addr_o, bus.wr_perm_o},
`ifdef RV_IOPMP_ENCODER_TOR_EN
                  {1'b1, 4'd2, 2'(OFF), 64'h401, 3'b110});
`else
                  {1'b1, 4'd2, 2'(NA4), 64'h401, 3'b110});
`endif
        end
        @(posedge clk); #1 bus.wr_ready_i = 1'b1;
        drain();

        // Asynchronous reset in the middle of EMIT
        bus.wr_ready_i = 1'b0;
        send_req(64'h1004, 64'hC, 3'b101, 0, 15);
        @(negedge clk); #2 rst_n = 1'b0;
        #1 check_reset_outputs();
        sb.delete();
        bus.wr_ready_i = 1'b1;
        @(posedge clk); #1 rst_n = 1'b1;

        exp_wr(0, NA4, 64'h400, 3'b001); exp_rsp(2'd0, 1);
        send_req(64'h1000, 64'h4, 3'b001, 0, 15); drain();

        check("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rv_iopmp_entry_encoder.md
RV_IOPMP_ENTRY_ENCODER -- requirements
Module: rv_iopmp_entry_encoder

Interface
REQ-001 SHALL have parameter LEN, default 32, meaning entry addr/addrh register width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 64, meaning transaction address and length width.
REQ-003 SHALL have parameter NUM_ENTRIES, default 16, meaning entry table depth; IDX_W = $clog2(NUM_ENTRIES).
REQ-004 SHALL have ports: clk_i  in  1  clock; rst_ni  in  1  asynchronous active-low reset.
REQ-005 SHALL have ports: req_valid_i  in  1; req_ready_o  out  1; req_base_i  in  ADDR_WIDTH  region base; req_len_i  in  ADDR_WIDTH  region length in bytes; req_perm_i  in  3  R/W/X permissions; req_idx_i  in  IDX_W  first entry; req_last_i  in  IDX_W  last usable entry.
REQ-006 SHALL have ports: wr_valid_o  out  1; wr_ready_i  in  1; wr_idx_o  out  IDX_W; wr_addr_o  out  LEN; wr_addrh_o  out  LEN; wr_mode_o  out  rv_iopmp_pkg::mode_t; wr_perm_o  out  3.
REQ-007 SHALL have ports: rsp_valid_o  out  1; rsp_ready_i  in  1; rsp_err_o  out  2  (0 OK, 1 ALIGN, 2 NO_ENTRIES, 3 RANGE); rsp_count_o  out  IDX_W+1  entries written.

Function
REQ-008 SHALL implement FSM states IDLE, EMIT, RESP; req_ready_o=1 only in IDLE, wr_valid_o=1 only in EMIT, rsp_valid_o=1 only in RESP.
REQ-009 SHALL in IDLE on req_valid_i&req_ready_o register base, len, perm, idx, last, clear count, and go to EMIT, or to RESP with error and no writes when a check fails.
REQ-010 SHALL flag ALIGN when req_base_i[1:0]!=0, req_len_i[1:0]!=0 or req_len_i==0; RANGE when base+len (ADDR_WIDTH+1 bits) exceeds 2^ADDR_WIDTH or req_idx_i>req_last_i; ALIGN has priority over RANGE.
REQ-011 SHALL in EMIT choose block exponent k = min(trailing zeros of current base, floor(log2(remaining))), with trailing zeros of base 0 taken as ADDR_WIDTH.
REQ-012 SHALL encode k==2 as mode NA4 with entry value base>>2, and k>=3 as mode NAPOT with value (base>>2) | ((1<<(k-3))-1); {wr_addrh_o,wr_addr_o} is that value zero-extended to 2*LEN bits (entry bits 65:2).
REQ-013 SHALL drive wr_idx_o=current idx and wr_perm_o=registered perm, and hold all wr_* outputs stable while wr_valid_o&!wr_ready_i.
REQ-014 SHALL on wr handshake add 2^k to base, subtract 2^k from remaining, increment idx and count; one write per handshake, zero bubble cycles between writes.
REQ-015 SHALL go to RESP with OK when remaining becomes 0, else with NO_ENTRIES when the written idx equals req_last (already-written entries are not rolled back).
REQ-016 SHALL in RESP hold rsp_err_o and rsp_count_o stable until rsp_ready_i, then return to IDLE; a new request is accepted no earlier than the cycle after the response handshake.
REQ-017 SHALL treat base+2^k reaching 2^ADDR_WIDTH at the last block as legal (no wrap error).

Reset
REQ-018 SHALL on rst_ni low, asynchronously and at any state including mid-EMIT, enter IDLE with req_ready_o=1 after release, wr_valid_o=0, rsp_valid_o=0, rsp_err_o=0, rsp_count_o=0, wr_idx_o=0, wr_addr_o=0, wr_addrh_o=0, wr_mode_o=OFF, wr_perm_o=0.

Configuration
REQ-019 SHALL support macro RV_IOPMP_ENCODER_TOR_EN: when defined, a region that is not one naturally aligned power-of-two block is encoded as two writes, entry idx mode OFF value base>>2, then entry idx+1 mode TOR value (base+len)>>2, needing idx+1<=last (else NO_ENTRIES before any write); single-block regions still use REQ-012.
REQ-020 SHALL, without RV_IOPMP_ENCODER_TOR_EN, use only NA4/NAPOT decomposition per REQ-011..015 and never emit mode TOR.

Verification
REQ-021 SHALL test base 0x8000_0000, len 0x1000, idx 0, last 15 -> one write idx 0 NAPOT value 0x2000_01FF; rsp OK, count 1.
REQ-022 SHALL test base 0x1000, len 0x4 -> one write NA4 value 0x400; rsp OK, count 1.
REQ-023 SHALL test base 0x1004, len 0xC -> without macro: NA4 0x401 at idx 0, NAPOT 0x402 at idx 1; with macro: OFF 0x401 at idx 0, TOR 0x404 at idx 1; count 2 both.
REQ-024 SHALL test base 0x1002, len 0x10 -> no write, rsp ALIGN, count 0; base 0x1004, len 0x1FFC, idx 14, last 15 -> writes NA4 0x401 idx 14, NAPOT 0x402 idx 15, rsp NO_ENTRIES, count 2 (without macro).
REQ-025 SHALL test wr_ready_i low 5 cycles mid-sequence -> wr_* stable; then rst_ni low mid-EMIT -> all outputs at REQ-018 values, next request processed normally.
